// File: rtl/vertical_motion_ctrl_if.sv
// Bus bundle for vertical_motion_ctrl: frame/button/collision inputs and the
// position, velocity and status outputs. The design attaches to the slave side.
interface vertical_motion_ctrl_if;
  logic              frame_tick;
  logic              jump_btn;
  logic              touching_platform;
  logic [9:0]        y_pos;
  logic [9:0]        next_y;
  logic signed [7:0] vel_y;
  logic              grounded;
  logic              respawning;
  logic              landed;

  modport master (
    output frame_tick, jump_btn, touching_platform,
    input  y_pos, next_y, vel_y, grounded, respawning, landed
  );

  modport slave (
    input  frame_tick, jump_btn, touching_platform,
    output y_pos, next_y, vel_y, grounded, respawning, landed
  );
endinterface

// File: rtl/vertical_motion_ctrl.sv
// Per-frame vertical physics for a platformer character: gravity, double jump,
// landing on a platform and a timed respawn after falling off screen.
module vertical_motion_ctrl #(
  parameter int HEIGHT         = 16,
  parameter int PLATFORM_Y     = 410,
  parameter int SPAWN_Y        = 100,
  parameter int GRAVITY        = 1,
  parameter int JUMP_VEL       = 12,
  parameter int MAX_FALL       = 10,
  parameter int MAX_JUMPS      = 2,
  parameter int SCREEN_H       = 480,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  vertical_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_AIR = 2'd0,
    ST_GND = 2'd1,
    ST_RSP = 2'd2
  } state_t;

  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int JMP_W = $clog2(MAX_JUMPS + 1);

  localparam logic [9:0]        GROUND_Y  = 10'(PLATFORM_Y - 2 * HEIGHT);
  localparam logic [9:0]        SPAWN_ROW = 10'(SPAWN_Y);
  localparam logic [9:0]        SCREEN_Y  = 10'(SCREEN_H);
  localparam logic signed [7:0] JUMP_V    = 8'(-JUMP_VEL);
  localparam logic signed [8:0] FALL_MAX  = 9'(MAX_FALL);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [JMP_W-1:0]  JMP_MAX   = JMP_W'(MAX_JUMPS);

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_y, w_y_nxt;
  logic signed [7:0] r_vel, w_vel_nxt, w_vel_sat;
  logic [JMP_W-1:0]  r_jumps, w_jumps_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_btn_q, r_jump_req, r_landed;
  logic              w_rise, w_consume, w_land;
  logic signed [10:0] w_sum;
  logic signed [8:0]  w_vel_g;
  logic [9:0]        w_air_y, w_next_y;
  logic              w_grounded, w_respawning;

  assign w_rise = bus.jump_btn & ~r_btn_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_AIR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, jump request latch and landing pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y        <= SPAWN_ROW;
      r_vel      <= 8'sd0;
      r_jumps    <= '0;
      r_cnt      <= '0;
      r_btn_q    <= 1'b0;
      r_jump_req <= 1'b0;
      r_landed   <= 1'b0;
    end else begin
      r_y      <= w_y_nxt;
      r_vel    <= w_vel_nxt;
      r_jumps  <= w_jumps_nxt;
      r_cnt    <= w_cnt_nxt;
      r_btn_q  <= bus.jump_btn;
      r_landed <= w_land;
      // A fresh edge arriving as the old request is consumed starts a new one
      if (r_state == ST_RSP) begin
        r_jump_req <= 1'b0;
      end else begin
        r_jump_req <= (r_jump_req & ~w_consume) | w_rise;
      end
    end
  end

  // Candidate row and saturated gravity step
  always_comb begin
    w_sum   = $signed({1'b0, r_y}) + $signed({{3{r_vel[7]}}, r_vel});
    w_vel_g = $signed({r_vel[7], r_vel}) + 9'sd1 * $signed(9'(GRAVITY));
    if (w_sum[10]) begin
      w_air_y = 10'd0;
    end else begin
      w_air_y = w_sum[9:0];
    end
    if (w_vel_g > FALL_MAX) begin
      w_vel_sat = 8'(MAX_FALL);
    end else begin
      w_vel_sat = w_vel_g[7:0];
    end
  end

  // Next-state and datapath update on frame ticks
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    w_jumps_nxt = r_jumps;
    w_cnt_nxt   = r_cnt;
    w_consume   = 1'b0;
    w_land      = 1'b0;
    if (bus.frame_tick) begin
      case (r_state)
        ST_AIR: begin
          if (bus.touching_platform && !r_vel[7]) begin
            w_y_nxt     = GROUND_Y;
            w_vel_nxt   = 8'sd0;
            w_jumps_nxt = '0;
            w_state_nxt = ST_GND;
            w_land      = 1'b1;
          end else if (w_next_y >= SCREEN_Y) begin
            w_state_nxt = ST_RSP;
            w_cnt_nxt   = '0;
          end else if (r_jump_req && (r_jumps < JMP_MAX)) begin
            w_vel_nxt   = JUMP_V;
            w_jumps_nxt = r_jumps + JMP_W'(1);
            w_consume   = 1'b1;
          end else begin
            w_y_nxt   = w_next_y;
            w_vel_nxt = w_vel_sat;
          end
        end
        ST_GND: begin
          if (r_jump_req) begin
            w_vel_nxt   = JUMP_V;
            w_jumps_nxt = JMP_W'(1);
            w_state_nxt = ST_AIR;
            w_consume   = 1'b1;
          end else if (!bus.touching_platform) begin
            w_vel_nxt   = 8'sd0;
            w_jumps_nxt = JMP_W'(1);
            w_state_nxt = ST_AIR;
          end else begin
            w_state_nxt = ST_GND;
          end
        end
        ST_RSP: begin
          if (r_cnt == CNT_LAST) begin
            w_y_nxt     = SPAWN_ROW;
            w_vel_nxt   = 8'sd0;
            w_jumps_nxt = '0;
            w_state_nxt = ST_AIR;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_AIR;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State-decoded outputs; grounded probes one row below to keep contact alive
  always_comb begin
    w_grounded   = 1'b0;
    w_respawning = 1'b0;
    w_next_y     = r_y;
    case (r_state)
      ST_AIR: begin
        w_next_y = w_air_y;
      end
      ST_GND: begin
        w_grounded = 1'b1;
        w_next_y   = r_y + 10'd1;
      end
      ST_RSP: begin
        w_respawning = 1'b1;
      end
      default: begin
        w_next_y = r_y;
      end
    endcase
  end

  assign bus.y_pos      = r_y;
  assign bus.next_y     = w_next_y;
  assign bus.vel_y      = r_vel;
  assign bus.grounded   = w_grounded;
  assign bus.respawning = w_respawning;
  assign bus.landed     = r_landed;

endmodule
